// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, one-request-at-a-time memory handshake and single-cycle issue
// to the decoder, which can redirect, inject a micro-instruction or end the program.
module instr_fetch #(
  parameter int unsigned           ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic              imem_req_o,
  input  logic [15:0]       imem_rdata_i,
  input  logic              imem_valid_i,
  input  logic              stall_i,
  output logic [15:0]       instr_o,
  output logic              instr_valid_o,
  output logic [ADDR_W-1:0] pc_o,
  input  logic              branch_i,
  input  logic [11:0]       branch_offset_i,
  input  logic [15:0]       self_instruct_i,
  input  logic              self_instruct_en_i,
  input  logic              end_program_i,
  output logic              halted_o
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       ir;
  logic              injected;
  logic              req;
  logic              issue;
  logic              halted;

  // Target is relative to the instruction after next (pc+4); the offset counts halfwords.
  function automatic logic [ADDR_W-1:0] branch_target(input logic [ADDR_W-1:0] base,
                                                       input logic [11:0]       off);
    logic signed [ADDR_W-1:0] disp;
    logic        [ADDR_W-1:0] sum;
    disp = {{(ADDR_W-12){off[11]}}, off};
    sum  = base + ADDR_W'(4) + $unsigned(disp <<< 1);
    return {sum[ADDR_W-1:1], 1'b0};
  endfunction

  function automatic logic [ADDR_W-1:0] seq_next(input logic [ADDR_W-1:0] base);
    logic [ADDR_W-1:0] sum;
    sum = base + ADDR_W'(2);
    return {sum[ADDR_W-1:1], 1'b0};
  endfunction

  // The req flop is high for the whole FETCH cycle. After reset FETCH spends one cycle
  // arming it, because reset leaves req low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      injected <= 1'b0;
      req      <= 1'b0;
      issue    <= 1'b0;
      halted   <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (req) begin
            req   <= 1'b0;
            state <= WAIT;
          end else begin
            req <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_valid_i) begin
            ir       <= imem_rdata_i;
            injected <= 1'b0;
            issue    <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (!stall_i) begin
            if (end_program_i) begin
              issue  <= 1'b0;
              halted <= 1'b1;
              state  <= HALT;
            end else if (self_instruct_en_i && !injected) begin
              ir       <= self_instruct_i;
              injected <= 1'b1;
            end else begin
              issue <= 1'b0;
              req   <= 1'b1;
              state <= FETCH;
              pc    <= (branch_i && !injected) ? branch_target(pc, branch_offset_i)
                                               : seq_next(pc);
            end
          end
        end
        HALT: begin
          issue <= 1'b0;
          req   <= 1'b0;
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign imem_addr_o   = pc;
  assign imem_req_o    = req;
  assign instr_o       = ir;
  assign instr_valid_o = issue;
  assign pc_o          = pc;
  assign halted_o      = halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: the memory is played inline by the stimulus sequence;
// expectations are hand-computed addresses, instructions and cycle distances.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] pc;
  logic        branch;
  logic [11:0] branch_offset;
  logic [15:0] self_instr;
  logic        self_en;
  logic        end_program;
  logic        halted;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_req = 0;

  instr_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .imem_addr_o        (imem_addr),
    .imem_req_o         (imem_req),
    .imem_rdata_i       (imem_rdata),
    .imem_valid_i       (imem_valid),
    .stall_i            (stall),
    .instr_o            (instr),
    .instr_valid_o      (instr_valid),
    .pc_o               (pc),
    .branch_i           (branch),
    .branch_offset_i    (branch_offset),
    .self_instruct_i    (self_instr),
    .self_instruct_en_i (self_en),
    .end_program_i      (end_program),
    .halted_o           (halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input logic [15:0] addr);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", {16'd0, imem_addr}, {16'd0, addr});
    chk("valid_low_at_req", {31'd0, instr_valid}, 32'd0);
    last_req = cyc;
  endtask

  // Request seen now; memory answers lat cycles later, issue follows one cycle after that.
  task automatic fetch_one(input logic [15:0] addr, input logic [15:0] data, input int lat);
    wait_req(addr);
    @(negedge clk);
    chk("req_one_cycle", {31'd0, imem_req}, 32'd0);
    repeat (lat - 1) @(negedge clk);
    chk("no_issue_in_wait", {31'd0, instr_valid}, 32'd0);
    imem_valid = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = 16'hFFFF;
    chk("issue_valid", {31'd0, instr_valid}, 32'd1);
    chk("issue_instr", {16'd0, instr}, {16'd0, data});
    chk("issue_pc", {16'd0, pc}, {16'd0, addr});
    chk("req_to_issue", cyc - last_req, lat + 1);
  endtask

  initial begin
    int prev;
    int t_rel;
    int nreq;
    rst = 1'b1; imem_rdata = 16'h0; imem_valid = 1'b0; stall = 1'b0;
    branch = 1'b0; branch_offset = 12'h0; self_instr = 16'h0; self_en = 1'b0;
    end_program = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", {16'd0, imem_addr}, 32'h0);
    chk("rst_instr", {16'd0, instr}, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc", {16'd0, pc}, 32'h0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    rst = 1'b0;

    // Sequential fetch, 3 cycles apart
    fetch_one(16'h0000, 16'h1C08, 1);
    prev = last_req;
    fetch_one(16'h0002, 16'h2005, 1);
    chk("seq_spacing_1", last_req - prev, 3);
    prev = last_req;
    fetch_one(16'h0004, 16'h3001, 1);
    chk("seq_spacing_2", last_req - prev, 3);

    // Branches: 4+4+8=0x10, 0x10+4-8=0x0C, 0x0C+4+0=0x10, 0x10+4+10=0x1E
    branch = 1'b1; branch_offset = 12'h004;
    @(negedge clk);
    branch = 1'b0;
    fetch_one(16'h0010, 16'h5555, 1);
    branch = 1'b1; branch_offset = 12'hFFC;
    @(negedge clk);
    branch = 1'b0;
    fetch_one(16'h000C, 16'h5556, 1);
    branch = 1'b1; branch_offset = 12'h000;
    @(negedge clk);
    branch = 1'b0;
    fetch_one(16'h0010, 16'h5557, 1);
    branch = 1'b1; branch_offset = 12'h005;
    @(negedge clk);
    branch = 1'b0;
    fetch_one(16'h001E, 16'hB500, 1);

    // Push injection; the branch alongside it and the repeated inject are ignored
    self_en = 1'b1; self_instr = 16'h9701; branch = 1'b1; branch_offset = 12'h010;
    @(negedge clk);
    chk("inj_valid", {31'd0, instr_valid}, 32'd1);
    chk("inj_instr", {16'd0, instr}, 32'h9701);
    chk("inj_pc", {16'd0, pc}, 32'h001E);
    chk("inj_no_req", {31'd0, imem_req}, 32'd0);
    self_instr = 16'hBEEF;
    @(negedge clk);
    self_en = 1'b0; branch = 1'b0;
    chk("inj_second_ignored", {16'd0, instr}, 32'h9701);
    fetch_one(16'h0020, 16'h4444, 4);

    // Stall for 3 issue cycles; feedback during the stall is ignored
    stall = 1'b1; end_program = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_instr", {16'd0, instr}, 32'h4444);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_pc", {16'd0, pc}, 32'h0020);
      chk("stall_no_req", {31'd0, imem_req}, 32'd0);
      chk("stall_not_halted", {31'd0, halted}, 32'd0);
    end
    stall = 1'b0; end_program = 1'b0;
    t_rel = cyc;
    fetch_one(16'h0022, 16'h2222, 1);
    chk("stall_release_one_advance", last_req - t_rel, 1);

    // Program end
    end_program = 1'b1;
    @(negedge clk);
    end_program = 1'b0;
    chk("halt_set", {31'd0, halted}, 32'd1);
    chk("halt_valid_low", {31'd0, instr_valid}, 32'd0);
    nreq = 0;
    repeat (8) begin
      @(negedge clk);
      if (imem_req === 1'b1) nreq++;
    end
    chk("halt_no_req", nreq, 0);
    chk("halt_sticky", {31'd0, halted}, 32'd1);

    // Reset out of HALT, then reset again during WAIT with a stale valid afterwards
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_halted", {31'd0, halted}, 32'd0);
    chk("rst2_pc", {16'd0, pc}, 32'h0);
    wait_req(16'h0000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    imem_valid = 1'b1; imem_rdata = 16'hDEAD;
    @(negedge clk);
    imem_valid = 1'b0; imem_rdata = 16'hFFFF;
    chk("stale_no_issue", {31'd0, instr_valid}, 32'd0);
    chk("stale_instr_clear", {16'd0, instr}, 32'h0);
    fetch_one(16'h0000, 16'h1111, 1);

    // Wrap-around: 0+4-6 = 0xFFFE, then sequential to 0x0000
    branch = 1'b1; branch_offset = 12'hFFD;
    @(negedge clk);
    branch = 1'b0;
    fetch_one(16'hFFFE, 16'h7777, 1);
    fetch_one(16'h0000, 16'h8888, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly upstream of the control unit. Holds the program counter, fetches 16-bit Thumb-style instructions from instruction memory through a request/valid handshake, and presents each one for a single decode cycle. Reacts to the decoder's same-cycle feedback: branch redirect, injection of self-generated micro-instructions (push/pop sequencing) and program end.

## Interface
- `RESET_PC`, default 16'h0000: PC loaded on reset; bit 0 must be 0.
- `ADDR_W`, default 16: PC and memory address width.

- `clk_i` in 1: clock. One clock; all state updates on its rising edge.
- `rst_i` in 1: reset. Synchronous and active-high.
- `imem_addr_o` out ADDR_W: fetch address, equal to the PC.
- `imem_req_o` out 1: single-cycle fetch request.
- `imem_rdata_i` in 16: fetched instruction.
- `imem_valid_i` in 1: `imem_rdata_i` valid; returned at least 1 cycle after the request.
- `stall_i` in 1: downstream not ready; hold the current issue.
- `instr_o` out 16: instruction to decode; drives the control unit `in`.
- `instr_valid_o` out 1: issue strobe; drives `cu_input_en_i`.
- `pc_o` out ADDR_W: address of `instr_o`; for an injected instruction, the address of its parent.
- `branch_i` in 1: take branch; sampled only in an issue cycle.
- `branch_offset_i` in 12: signed halfword offset, already sign-extended by the datapath.
- `self_instruct_i` in 16: micro-instruction to inject.
- `self_instruct_en_i` in 1: inject request.
- `end_program_i` in 1: stop fetching.
- `halted_o` out 1: halted, sticky.

## Operation
- State machine states: FETCH, WAIT, ISSUE, HALT.
- On reset:
  - pc=RESET_PC; state=FETCH.
  - Outputs: `imem_req_o`=0, `imem_addr_o`=RESET_PC, `instr_o`=0, `instr_valid_o`=0, `pc_o`=RESET_PC, `halted_o`=0.
  - The injected flag is cleared.
- FETCH:
  - `imem_req_o`=1 for exactly one cycle; go to WAIT.
- WAIT:
  - Hold until `imem_valid_i`.
  - Then IR<=`imem_rdata_i`, injected flag<=0, go to ISSUE.
- ISSUE:
  - `instr_valid_o`=1; `instr_o`=IR; `pc_o`=pc.
  - While `stall_i`=1: all state, IR and outputs stay frozen and decoder feedback is ignored.
  - When `stall_i`=0, the feedback is evaluated in the same cycle (the decoder is combinational), in this priority order:
    1. `end_program_i` → HALT.
    2. `self_instruct_en_i` and injected flag=0 → IR<=`self_instruct_i`, injected flag<=1, pc unchanged, stay in ISSUE. Any `branch_i` in that cycle is ignored.
    3. `branch_i` and injected flag=0 → pc<=pc+4+(sext(`branch_offset_i`)<<1), go to FETCH.
    4. Otherwise → pc<=pc+2, go to FETCH.
  - In an injected issue, `self_instruct_en_i` and `branch_i` are ignored: at most one injection per fetched instruction, and injected instructions never branch.
- HALT:
  - `halted_o`=1; `instr_valid_o`=0; no requests.
  - Left only by `rst_i`.
- Arithmetic:
  - PC arithmetic is modulo 2^ADDR_W; wrap-around from the top address to 0 is silent.
  - pc[0] stays 0.
- `imem_valid_i` outside WAIT is ignored.
- `stall_i` outside ISSUE has no effect.
- `rst_i` mid-operation (any state, including WAIT with a request outstanding): the next state is FETCH at RESET_PC. The memory shares `rst_i` and drops outstanding requests.
- `instr_o` while `instr_valid_o`=0:
  - Holds the last IR, or 0 after reset.
  - The consumer must gate on `instr_valid_o`, because 0 decodes as end-of-program.

## Timing
- With 1-cycle memory:
  - req at cycle t, valid at t+1, issue at t+2, next req at t+3.
  - 3 cycles per sequential instruction.
- Memory latency of L cycles gives L+2 cycles per instruction.
- An injection adds exactly 1 issue cycle with no memory access.
- A branch takes effect at the FETCH following the issue; there are no wrong-path fetches.
- End of program: `halted_o` rises the cycle after the issue of the end instruction.

## Test plan
- Reset, sequential fetch:
  - Stimulus: RESET_PC=0; memory returns 1-cycle data 16'h1C08, 16'h2005, 16'h3001.
  - Required: `imem_addr_o` sequence 0, 2, 4; `instr_valid_o` high 1 cycle per instruction, 3 cycles apart; `pc_o` matches each instruction.
- Branch:
  - Stimulus: issue at pc=0x0010 with `branch_i`=1, `branch_offset_i`=12'hFFC (−4).
  - Required: next fetch address 0x000C. With offset 12'h005, the next fetch address is 0x001E.
- Push injection:
  - Stimulus: fetched 16'hB500; `self_instruct_en_i`=1, `self_instruct_i`=16'h9701.
  - Required: next cycle `instr_o`=16'h9701 with `pc_o` unchanged; a repeated `self_instruct_en_i` in that cycle is ignored; the following fetch address is pc+2.
- Stall and variable latency:
  - Stimulus: `imem_valid_i` 4 cycles after the request; `stall_i`=1 for 3 issue cycles.
  - Required: `instr_o` stable and `instr_valid_o` held high during the stall; exactly one advance after the stall is released.
- Halt and reset:
  - Stimulus: `end_program_i` at an issue.
  - Required: `halted_o`=1 with no further `imem_req_o`.
  - Stimulus: assert `rst_i` during WAIT, then deassert.
  - Required: fetch restarts at RESET_PC; the stale `imem_valid_i` is ignored.
- Wrap-around:
  - Stimulus: ADDR_W=16, pc=0xFFFE, sequential issue.
  - Required: next fetch address 0x0000.
